// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks: active-low glyphs
// (bit 6 = a ... bit 0 = g), the blank pattern and the default prescale.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h60;
    localparam logic [6:0] GLYPH_C = 7'h31;
    localparam logic [6:0] GLYPH_D = 7'h42;
    localparam logic [6:0] GLYPH_E = 7'h30;
    localparam logic [6:0] GLYPH_F = 7'h38;

    // 100 MHz clock / 100000 gives a 1 kHz digit rate.
    localparam int REFRESH_DIV_DEFAULT = 100000;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low common-anode segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup for 0-9, A, b, C, d, E, F.
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver: snapshots data_in tear-free at frame
// boundaries and scans DIGITS common-anode digits, one slot per
// REFRESH_DIV clocks, with decimal points and leading-zero blanking.
// Optional digit blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter int DW          = 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     data_in,
    input  logic              upd,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] blink_mask,
    output logic              busy,
    output logic              frame_done,
    output logic [6:0]        a_to_g,
    output logic [DIGITS-1:0] AN,
    output logic              DP
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              tick;
    logic              wrap;
    logic [DW-1:0]     pending;
    logic [DW-1:0]     shadow;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              lz_blank;
    logic              blink_on;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [DIGITS-1:0] an_next;

    assign tick = (cnt == CW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // Prescaler and digit index; the index advances once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture handshake: upd always lands in pending; shadow only moves at
    // the frame wrap, so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            shadow     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap) begin
                shadow <= pending;
            end
            if (upd) begin
                pending <= data_in;
                busy    <= 1'b1;
            end else if (wrap) begin
                busy <= 1'b0;
            end
        end
    end

    assign nibble = shadow[4*idx +: 4];

    hex_to_seg7 u_dec (
        .hex (nibble),
        .seg (glyph)
    );

`ifdef SEG7_BLINK_EN
    logic [6:0] frame_cnt;

    // Frame counter; its MSB gates blinking digits for half of each
    // 128-frame period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink_on = frame_cnt[6] && blink_mask[idx];
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_on     = 1'b0;
`endif

    // Next-slot glyph, blanking and decimal point for the current digit.
    always_comb begin
        lz_blank = blank_lz && (idx != '0) && ((shadow >> {idx, 2'b00}) == '0);
        seg_next = (lz_blank || blink_on) ? SEG_BLANK : glyph;
        dp_next  = blink_on ? 1'b1 : ~dp_mask[idx];
        an_next  = ~(DIGITS'(1) << idx);
    end

    // Registered display outputs, reloaded on each slot tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN     <= '1;
            a_to_g <= SEG_BLANK;
            DP     <= 1'b1;
        end else if (tick) begin
            AN     <= an_next;
            a_to_g <= seg_next;
            DP     <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIGITS=8, REFRESH_DIV=4. Define
// SEG7_BLINK_EN for both bench and design to exercise blinking.
module tb_seg7_scan_driver;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int DW     = 4 * DIGITS;
    localparam int FRAME  = DIGITS * DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     data_in = '0;
    logic              upd = 1'b0;
    logic [DIGITS-1:0] dp_mask = '0;
    logic              blank_lz = 1'b0;
    logic [DIGITS-1:0] blink_mask = '0;
    logic              busy;
    logic              frame_done;
    logic [6:0]        a_to_g;
    logic [DIGITS-1:0] AN;
    logic              DP;

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (DIV),
        .DW          (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .upd        (upd),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .busy       (busy),
        .frame_done (frame_done),
        .a_to_g     (a_to_g),
        .AN         (AN),
        .DP         (DP)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: edges since reset release, pending/shown words,
    // and the snapshot of live inputs taken at the start of the shown slot.
    int          n;
    logic [31:0] m_pending, m_shadow, d_shadow;
    logic        m_busy, m_fd, d_valid, d_blz;
    logic [7:0]  d_dp, d_blink;
    int          d_digit, m_frames, d_frames;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_pending = '0;
        m_shadow = '0;
        m_busy = 1'b0;
        m_fd = 1'b0;
        d_valid = 1'b0;
        m_frames = 0;
        d_frames = 0;
    endtask

    task automatic model_edge();
        n++;
        m_fd = 1'b0;
        if (n % DIV == 0) begin
            d_valid  = 1'b1;
            d_digit  = (n / DIV - 1) % DIGITS;
            d_shadow = m_shadow;
            d_blz    = blank_lz;
            d_dp     = dp_mask;
            d_blink  = blink_mask;
            d_frames = m_frames;
        end
        if (n % FRAME == 0) begin
            m_shadow = m_pending;
            m_busy   = 1'b0;
            m_fd     = 1'b1;
            m_frames++;
        end
        if (upd) begin
            m_pending = data_in;
            m_busy    = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        logic        blank;
        logic [31:0] upper;
        if (!d_valid) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            upper  = d_shadow >> (4 * d_digit);
            blank  = d_blz && (d_digit != 0) && (upper == 0);
            exp_dp = ~d_dp[d_digit];
`ifdef SEG7_BLINK_EN
            if (((d_frames / 64) % 2 == 1) && d_blink[d_digit]) begin
                blank  = 1'b1;
                exp_dp = 1'b1;
            end
`endif
            exp_seg = blank ? 7'h7F : glyph[upper[3:0]];
            exp_an  = ~(8'h01 << d_digit);
        end
        check_val("AN", 32'(AN), 32'(exp_an));
        check_val("a_to_g", 32'(a_to_g), 32'(exp_seg));
        check_val("DP", 32'(DP), 32'(exp_dp));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        glyph = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        model_reset();

        // Reset state, then release just after an edge.
        #12;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle scan with zero data.
        step(3 * FRAME);

        // Mid-frame update; old value stays until the wrap.
        step(FRAME / 2 - 3);
        data_in = 32'h0000_7FFF;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        step(2 * FRAME);

        // Leading-zero blanking, then an all-zero word.
        blank_lz = 1'b1;
        step(2 * FRAME);
        data_in = 32'h0;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        step(2 * FRAME);

        // Pending B, then A arriving on the exact wrap edge.
        blank_lz = 1'b0;
        data_in = 32'hBBBB_0001;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        while ((n + 1) % FRAME != 0) step(1);
        data_in = 32'hAAAA_1234;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        check_val("busy_after_wrap_upd", 32'(busy), 32'd1);
        step(2 * FRAME);

        // Single decimal point on digit 4.
        dp_mask = 8'h10;
        step(2 * FRAME);

        // Randomized traffic long enough to cross the blink half-periods.
        blink_mask = 8'h01;
        for (int f = 0; f < 140; f++) begin
            repeat (FRAME) begin
                if ($urandom_range(0, 15) == 0) begin
                    data_in = $urandom >> (4 * $urandom_range(0, 8));
                    upd = 1'b1;
                end else begin
                    upd = 1'b0;
                end
                if ($urandom_range(0, 63) == 0) dp_mask = 8'($urandom);
                if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
                if ($urandom_range(0, 255) == 0) blink_mask = 8'($urandom);
                step(1);
            end
        end
        upd = 1'b0;

        // Reset mid-scan with an update still pending.
        step(FRAME / 2 + 1);
        data_in = 32'h1234_5678;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        step(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step(2);
        rst_n = 1'b1;
        step(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the barrel-shifter datapath.
- Consumes the shifted result word plus operand/status nibbles, snapshots them tear-free at frame boundaries, and time-multiplexes 8 hex digits onto the board's common-anode seven-segment display.
- Provides refresh prescaling, per-digit decimal points and optional leading-zero blanking.

Parameters:
- DIGITS, 8, number of multiplexed digits (AN width).
- REFRESH_DIV, 100000, clk cycles per digit slot; 100 MHz gives a 1 kHz digit rate. Must be ≥2.
- DW, 4*DIGITS, width of data_in, one hex nibble per digit; nibble 0 maps to digit 0 (rightmost).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  DW  value to display
- upd  input  1  single-cycle request to capture data_in
- dp_mask  input  DIGITS  decimal point enable per digit, 1 = lit
- blank_lz  input  1  1 = blank leading zero digits
- blink_mask  input  DIGITS  digits to blink; used only when SEG7_BLINK_EN is defined, ignored otherwise
- busy  output  1  capture pending, not yet shown
- frame_done  output  1  one-cycle pulse at each frame wrap
- a_to_g  output  7  segments, active low, bit 6 = a … bit 0 = g
- AN  output  DIGITS  digit anodes, active low, one-hot-cold
- DP  output  1  decimal point, active low

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, digit index = 0, pending and shadow registers = 0, busy = 0, frame_done = 0.
  - AN = all ones, a_to_g = 7'h7F, DP = 1 (display dark).
- Prescaler:
  - Counts 0..REFRESH_DIV-1; tick = (count == REFRESH_DIV-1), then wraps to 0.
  - On tick, digit index increments modulo DIGITS.
- Outputs are registered, updated the cycle after tick.
  - The first AN assertion after reset is digit 0, REFRESH_DIV+1 cycles after release.
  - Exactly one AN bit is low at any time after that first tick.
- Capture handshake:
  - upd=1 loads data_in into pending and sets busy, regardless of busy; the last upd wins.
  - On a tick where the digit index wraps DIGITS-1→0: shadow ← pending, busy ← 0, frame_done = 1 for that cycle.
  - upd coinciding with the wrap tick: the new data goes to pending, busy stays 1, and shadow takes the pre-upd pending value.
- Digit decode: nibble of shadow[4k+3:4k] → hex glyphs 0-9, A, b, C, d, E, F (standard common-anode patterns).
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blank (a_to_g = 7'h7F) if all nibbles k..DIGITS-1 are zero and k≠0. Digit 0 is never blanked.
  - DP still follows dp_mask on blanked digits.
- DP = ~dp_mask[idx].
- blank_lz and dp_mask are sampled live each slot; only data_in is snapshotted.
- Reset mid-frame: display goes dark immediately, pending data is lost, and busy clears.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- Defined:
  - A frame counter of 7 bits increments on each frame_done.
  - While frame counter bit 6 = 1, digits with blink_mask[k]=1 show blank segments and unlit DP; AN scanning is unchanged.
  - Blink period is 128 frames (≈1 Hz at defaults).
  - The counter resets to 0.
- Undefined: no frame counter is built, and blink_mask has no effect.

Decomposition:
- Shared package seg7_pkg:
  - 16 glyph constants.
  - SEG_BLANK = 7'h7F.
  - Default REFRESH_DIV.
- One combinational sub-module, hex_to_seg7: 4-bit in, 7-bit active-low out. Reused by other display blocks.
- The scan counter, capture logic, blanking and blink logic stay in seg7_scan_driver.

Test Plan:
All scenarios use REFRESH_DIV=4, DIGITS=8.
- Reset then idle, data 0, blank_lz=0 → AN steps FE, FD, FB… every 4 cycles; a_to_g = 7'h01 ("0") on all digits; frame_done every 32 cycles.
- upd with data_in=32'h0000_7FFF mid-frame → busy=1 until the next wrap, and the old value is shown until then. Next frame: digit0-2 show F (7'h38), digit3 shows 7 (7'h0F).
- Same data with blank_lz=1 → digits 4-7 a_to_g=7'h7F, digits 0-3 as above. Data 32'h0 → only digit0 shows "0".
- upd on the exact wrap cycle with data A, preceded by pending B → shadow=B, busy stays 1, and A appears one frame later.
- dp_mask=8'h10 → DP=0 only while AN=8'hEF. Assert rst_n=0 mid-scan → AN=FF and a_to_g=7F the same cycle.
- With SEG7_BLINK_EN defined, blink_mask=8'h01 → digit0 blank for frames 64-127 and lit for frames 0-63. Without the macro, digit0 is always lit.
